// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - processor load/store request/response bundle
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Processor side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with modelled access latency
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  // RAM is word organised: ADDR_W byte-address bits, low two bits select the lane.
  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Request captured at acceptance; the processor may change its bus afterwards.
  logic             lat_we;
  logic             lat_unsigned;
  logic [1:0]       lat_size;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;

  logic [31:0]      rdata_q;
  logic             err_q;

  logic [31:0]      mem [WORDS];

  logic             accept;
  logic             finish;
  logic             align_err;
  logic             range_err;
  logic             req_err;
  logic             do_write;
  logic [ADDR_W-3:0] word_idx;
  logic [1:0]       lane;
  logic [3:0]       byte_en;
  logic [31:0]      wr_word;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;

  assign accept   = (state == S_IDLE) && bus.req_valid;
  assign finish   = (state == S_WAIT) && (cnt == '0);
  assign word_idx = lat_addr[ADDR_W-1:2];
  assign lane     = lat_addr[1:0];
  assign do_write = finish && lat_we && !req_err;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Classify the latched request: illegal size, misalignment, or beyond the RAM.
  always_comb begin
    align_err = 1'b0;
    case (lat_size)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = lat_addr[0];
      SZ_WORD: align_err = |lat_addr[1:0];
      default: align_err = 1'b1;
    endcase
    range_err = (lat_addr >> ADDR_W) != 32'd0;
    req_err   = align_err | range_err;
  end

  // Lane enables and store data replicated across lanes so any enabled lane sees its bytes.
  always_comb begin
    byte_en = 4'b0000;
    wr_word = lat_wdata;
    case (lat_size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << lane;
        wr_word = {4{lat_wdata[7:0]}};
      end
      SZ_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{lat_wdata[15:0]}};
      end
      SZ_WORD: begin
        byte_en = 4'b1111;
        wr_word = lat_wdata;
      end
      default: begin
        byte_en = 4'b0000;
        wr_word = lat_wdata;
      end
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {lane, 3'b000};
    case (lat_size)
      SZ_BYTE: load_data = lat_unsigned ? {24'd0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_data = lat_unsigned ? {16'd0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Sequencer: IDLE accepts, WAIT burns the latency budget, RESP holds until consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= CNT_LOAD;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture the request on the accept edge only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
    end else if (accept) begin
      lat_we       <= bus.req_we;
      lat_unsigned <= bus.req_unsigned;
      lat_size     <= bus.req_size;
      lat_addr     <= bus.req_addr;
      lat_wdata    <= bus.req_wdata;
    end
  end

  // Response registers load when the wait expires and stay frozen through RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (finish) begin
      rdata_q <= (lat_we || req_err) ? 32'd0 : load_data;
      err_q   <= req_err;
    end
  end

  // RAM write with byte enables; not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) begin
          mem[word_idx][8*k +: 8] <= wr_word[8*k +: 8];
        end
      end
    end
  end

endmodule
